// File: rtl/updn_counter_sat_pkg.sv
// Shared definitions for the signed up/down counter: range limits and the
// arithmetic mode enumeration.
package updn_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    function automatic int cnt_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int cnt_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/signed_step_alu.sv
// Combinational add/subtract of a signed step with overflow detection and
// optional clamping to the W-bit signed range.
module signed_step_alu
    import updn_counter_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] count,
    input  logic [W-1:0] b,
    input  logic         dir,
    input  mode_e        mode,
    output logic [W-1:0] result,
    output logic         of_hi,
    output logic         of_lo
);

    localparam logic [W-1:0] MAX_V = W'(cnt_max(W));
    localparam logic [W-1:0] MIN_V = W'(cnt_min(W));

    logic [W:0] count_x;
    logic [W:0] b_x;
    logic [W:0] next_increment;
    logic [W:0] next_decrement;
    logic [W:0] sum;

    // One guard bit keeps count - MIN exact, so every result fits in W+1 bits.
    assign count_x        = {count[W-1], count};
    assign b_x            = {b[W-1], b};
    assign next_increment = count_x + b_x;
    assign next_decrement = count_x - b_x;
    assign sum            = dir ? next_increment : next_decrement;

    // Guard bit disagreeing with the W-bit sign bit means the result left the range.
    assign of_hi = ~sum[W] & sum[W-1];
    assign of_lo = sum[W] & ~sum[W-1];

    always_comb begin
        result = sum[W-1:0];
        if (mode == MODE_SAT) begin
            if (of_hi) begin
                result = MAX_V;
            end else if (of_lo) begin
                result = MIN_V;
            end
        end
    end

endmodule

// File: rtl/updn_counter_sat.sv
// Signed up/down counter with programmable step, wrap or saturate mode,
// synchronous load and per-direction overflow pulses with sticky status.
module updn_counter_sat
    import updn_counter_pkg::*;
#(
    parameter int W           = 3,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                dn,
    input  logic signed [W-1:0] b,
    input  logic                load,
    input  logic signed [W-1:0] load_val,
    input  logic                sat,
    input  logic                clr_ovf,
    output logic signed [W-1:0] count,
    output logic                ovf_up,
    output logic                ovf_dn,
    output logic [1:0]          ovf_sticky
);

    localparam mode_e RESET_MODE = SAT_DEFAULT ? MODE_SAT : MODE_WRAP;

    mode_e        mode_q;
    logic         inc_cmd;
    logic         dec_cmd;
    logic         step_upd;
    logic [W-1:0] alu_result;
    logic         of_hi;
    logic         of_lo;
    logic         set_up;
    logic         set_dn;

    // Simultaneous up and dn cancel to a hold; load outranks any step.
    assign inc_cmd  = en & up & ~dn;
    assign dec_cmd  = en & dn & ~up;
    assign step_upd = ~load & (inc_cmd | dec_cmd);
    assign set_up   = step_upd & of_hi;
    assign set_dn   = step_upd & of_lo;

    signed_step_alu #(
        .W(W)
    ) u_alu (
        .count  (count),
        .b      (b),
        .dir    (inc_cmd),
        .mode   (mode_q),
        .result (alu_result),
        .of_hi  (of_hi),
        .of_lo  (of_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            ovf_up     <= 1'b0;
            ovf_dn     <= 1'b0;
            ovf_sticky <= 2'b00;
            mode_q     <= RESET_MODE;
        end else begin
            mode_q <= sat ? MODE_SAT : MODE_WRAP;
            ovf_up <= set_up;
            ovf_dn <= set_dn;
            if (load) begin
                count <= load_val;
            end else if (step_upd) begin
                count <= alu_result;
            end
            // A new overflow in the clearing cycle survives the clear.
            ovf_sticky <= (clr_ovf ? 2'b00 : ovf_sticky) | {set_dn, set_up};
        end
    end

endmodule
